// File: rtl/tx6b8b_pkg.sv
// tx6b8b_pkg: shared K-symbol codes and scheduler state encoding for the 6b8b TX scheduler
package tx6b8b_pkg;
    localparam logic [5:0] K_SYNC = 6'b011110;
    localparam logic [5:0] K_IDLE = 6'b100001;
    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, SYNC = 2'd2} state_t;
endpackage

// File: rtl/tx_6b8b_sched_if.sv
// tx_6b8b_sched_if: requester channels A (data) and B (data or K) into the symbol scheduler
interface tx_6b8b_sched_if;
    logic       a_valid;
    logic [5:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [5:0] b_data;
    logic       b_k;
    logic       b_ready;
    modport master (output a_valid, a_data, b_valid, b_data, b_k, input a_ready, b_ready);
    modport slave (input a_valid, a_data, b_valid, b_data, b_k, output a_ready, b_ready);
endinterface

// File: rtl/tx6b8b_arb.sv
// tx6b8b_arb: two-requester grant; round-robin when TX6B8B_SCHED_RR_EN is defined, else A over B
module tx6b8b_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_gnt,
    output logic b_gnt
);
`ifdef TX6B8B_SCHED_RR_EN
    logic last_b;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_b <= 1'b1;
        else if (a_gnt | b_gnt) last_b <= ~last_b;
    always_comb begin
        a_gnt = req & a_valid & (~b_valid | last_b);
        b_gnt = req & b_valid & (~a_valid | ~last_b);
    end
`else
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    always_comb begin
        a_gnt = req & a_valid;
        b_gnt = req & b_valid & ~a_valid;
    end
`endif
endmodule

// File: rtl/tx_6b8b_sched.sv
// tx_6b8b_sched: one 6-bit symbol per serializer request from init/periodic sync, channels A/B or idle
// Arbitration mode selected by TX6B8B_SCHED_RR_EN (see tx6b8b_arb).
module tx_6b8b_sched
    import tx6b8b_pkg::*;
#(
    parameter int SYNC_PERIOD = 1024,
    parameter int SYNC_BURST  = 4,
    parameter int INIT_SYNC   = 16,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sym_req,
    tx_6b8b_sched_if.slave ch,
    output logic          enc_k,
    output logic [5:0]    enc_din,
    output logic          enc_load,
    output logic          sync_active,
    output logic [1:0]    state
);
    localparam logic [CNT_W-1:0] PER_MAX    = CNT_W'(SYNC_PERIOD - SYNC_BURST - 1);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_SYNC - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(SYNC_BURST - 1);

    state_t           st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, per, per_nx;
    logic             wrap, done, req, a_gnt, b_gnt, sym_k, sym_sync;
    logic [5:0]       sym_din;

    // the request that enters SYNC issues idle and grants nobody
    assign wrap = (st == RUN) && (per == PER_MAX);
    assign done = cnt == ((st == INIT) ? INIT_LAST : BURST_LAST);
    assign req  = en & sym_req & (st == RUN) & ~wrap;

    tx6b8b_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_valid (ch.a_valid),
        .b_valid (ch.b_valid),
        .a_gnt   (a_gnt),
        .b_gnt   (b_gnt)
    );

    assign ch.a_ready = a_gnt;
    assign ch.b_ready = b_gnt;
    assign state      = st;

    always_comb begin
        st_nx    = st;
        cnt_nx   = cnt;
        per_nx   = per;
        sym_k    = 1'b1;
        sym_din  = K_IDLE;
        sym_sync = 1'b0;
        if (!en) begin
            st_nx  = INIT;
            cnt_nx = '0;
            per_nx = '0;
        end else if (sym_req) begin
            case (st)
                INIT, SYNC: begin
                    sym_din  = K_SYNC;
                    sym_sync = 1'b1;
                    st_nx    = done ? RUN : st;
                    cnt_nx   = done ? '0 : cnt + 1'b1;
                    per_nx   = done ? '0 : per;
                end
                RUN: begin
                    st_nx   = wrap ? SYNC : RUN;
                    per_nx  = wrap ? per : per + 1'b1;
                    sym_k   = ~a_gnt & (~b_gnt | ch.b_k);
                    sym_din = a_gnt ? ch.a_data : b_gnt ? ch.b_data : K_IDLE;
                end
                default: st_nx = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= INIT;
            cnt         <= '0;
            per         <= '0;
            enc_k       <= 1'b1;
            enc_din     <= K_IDLE;
            enc_load    <= 1'b0;
            sync_active <= 1'b0;
        end else begin
            st       <= st_nx;
            cnt      <= cnt_nx;
            per      <= per_nx;
            enc_load <= sym_req;
            if (sym_req) begin
                enc_k       <= sym_k;
                enc_din     <= sym_din;
                sync_active <= sym_sync;
            end
        end
    end
endmodule

// File: tb/tb_tx_6b8b_sched.sv
// tb_tx_6b8b_sched: directed checks of sync bursts, arbitration, enable and async reset behaviour
module tb_tx_6b8b_sched;
    import tx6b8b_pkg::*;

`ifdef TX6B8B_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0, sym_req = 1'b0;
    logic       enc_k, enc_load, sync_active;
    logic [5:0] enc_din;
    logic [1:0] state;
    int         n_chk = 0, n_err = 0;

    tx_6b8b_sched_if ch ();

    tx_6b8b_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sym_req     (sym_req),
        .ch          (ch),
        .enc_k       (enc_k),
        .enc_din     (enc_din),
        .enc_load    (enc_load),
        .sync_active (sync_active),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sym(input string tag, input logic k, input logic [5:0] d, input logic s);
        check({tag, "_load"}, enc_load, 1);
        check({tag, "_k"}, enc_k, k);
        check({tag, "_din"}, enc_din, d);
        check({tag, "_sync"}, sync_active, s);
    endtask

    task automatic init_burst(input string tag);
        for (int i = 0; i < 16; i++) begin
            #1;
            check({tag, "_a_rdy"}, ch.a_ready, 0);
            check({tag, "_b_rdy"}, ch.b_ready, 0);
            tick;
            expect_sym(tag, 1'b1, K_SYNC, 1'b1);
        end
        check({tag, "_state"}, state, 1);
    endtask

    initial begin
        logic exp_a, busy, found;
        ch.a_valid = 0; ch.a_data = 0; ch.b_valid = 0; ch.b_data = 0; ch.b_k = 0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_k", enc_k, 1);
        check("rst_din", enc_din, 6'h21);
        check("rst_load", enc_load, 0);
        check("rst_sync", sync_active, 0);
        check("rst_a_rdy", ch.a_ready, 0);
        check("rst_b_rdy", ch.b_ready, 0);

        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1; sym_req = 1'b1;
        init_burst("init");
        tick;
        expect_sym("idle", 1'b1, K_IDLE, 1'b0);

        ch.a_valid = 1; ch.a_data = 6'h0A; ch.b_valid = 1; ch.b_data = 6'h30; ch.b_k = 1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_a = RR ? (k % 2 == 0) : 1'b1;
            check("mix_a_rdy", ch.a_ready, exp_a);
            check("mix_b_rdy", ch.b_ready, !exp_a);
            tick;
            expect_sym("mix", !exp_a, exp_a ? 6'h0A : 6'h30, 1'b0);
        end

        ch.b_valid = 0; ch.a_data = 6'h15;
        for (int j = 7; j < 1030; j++) begin
            #1;
            busy = (j >= 1019) && (j < 1024);
            check("per_a_rdy", ch.a_ready, !busy);
            tick;
            expect_sym("per", busy, (j == 1019) ? K_IDLE : busy ? K_SYNC : 6'h15, busy && j != 1019);
            check("per_state", state, (j >= 1019 && j < 1023) ? 2 : 1);
        end

        for (int r = 0; r < 4; r++) begin
            ch.a_data = 6'h10 + 6'(r); sym_req = 1'b1;
            #1;
            check("pulse_a_rdy", ch.a_ready, 1);
            tick;
            sym_req = 1'b0; ch.a_data = 6'h3F;
            expect_sym("pulse", 1'b0, 6'h10 + 6'(r), 1'b0);
            #1;
            check("pulse_idle_rdy", ch.a_ready, 0);
            tick;
            check("pulse_hold_load", enc_load, 0);
            check("pulse_hold_din", enc_din, 6'h10 + 6'(r));
            tick;
            check("pulse_hold2_load", enc_load, 0);
            check("pulse_hold2_din", enc_din, 6'h10 + 6'(r));
        end

        ch.a_data = 6'h15; sym_req = 1'b1; en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("en0_a_rdy", ch.a_ready, 0);
            tick;
            expect_sym("en0", 1'b1, K_IDLE, 1'b0);
            check("en0_state", state, 0);
        end
        en = 1'b1;
        init_burst("reinit");
        #1;
        check("resume_a_rdy", ch.a_ready, 1);
        tick;
        expect_sym("resume", 1'b0, 6'h15, 1'b0);

        ch.a_valid = 0; ch.b_valid = 1;
        #1;
        check("bonly_b_rdy", ch.b_ready, 1);
        check("bonly_a_rdy", ch.a_ready, 0);
        tick;
        expect_sym("bonly_k", 1'b1, 6'h30, 1'b0);
        ch.b_k = 0; ch.b_data = 6'h05;
        tick;
        expect_sym("bonly_d", 1'b0, 6'h05, 1'b0);
        ch.b_valid = 0; ch.a_valid = 1;

        found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            tick;
            found = (state == 2);
        end
        check("sync_found", found, 1);
        tick;
        expect_sym("burst", 1'b1, K_SYNC, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_k", enc_k, 1);
        check("arst_din", enc_din, 6'h21);
        check("arst_load", enc_load, 0);
        check("arst_sync", sync_active, 0);
        check("arst_a_rdy", ch.a_ready, 0);
        tick;
        rst_n = 1'b1;
        init_burst("rst_init");
        #1;
        check("rst_resume_rdy", ch.a_ready, 1);
        tick;
        expect_sym("rst_resume", 1'b0, 6'h15, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
